// File: rtl/jtkcpu_pkg.sv
// jtkcpu_pkg
// Shared constants for the interrupt scheduler and the memory controller:
//   - one-hot vector codes handed to the memory controller (VEC_*)
//   - interrupt scheduler FSM state encoding
//   - helper deciding whether a serviced source also masks FIRQ
package jtkcpu_pkg;

  localparam logic [3:0] VEC_NONE = 4'b0000;
  localparam logic [3:0] VEC_IRQ  = 4'b0001;
  localparam logic [3:0] VEC_FIRQ = 4'b0010;
  localparam logic [3:0] VEC_NMI  = 4'b0100;
  localparam logic [3:0] VEC_RST  = 4'b1000;

  typedef enum logic [1:0] {
    ST_RSTV = 2'd0,
    ST_IDLE = 2'd1,
    ST_PUSH = 2'd2,
    ST_VEC  = 2'd3
  } int_state_t;

  // Every source sets I; only IRQ leaves F untouched.
  function automatic logic sets_f(input logic [3:0] vec);
    return vec != VEC_IRQ;
  endfunction

endpackage

// File: rtl/jtkcpu_intsched_if.sv
// jtkcpu_intsched_if
// Bundle between the CPU core (master) and the interrupt scheduler (slave).
//   master drives: cen, nmi_n, firq_n, irq_n, mask_i, mask_f, fetch,
//                  psh_done, up_pc
//   slave drives : int_req, push_all, intvec[3:0], set_i, set_f, nmi_armed
interface jtkcpu_intsched_if;
  import jtkcpu_pkg::*;

  logic       cen;
  logic       nmi_n;
  logic       firq_n;
  logic       irq_n;
  logic       mask_i;
  logic       mask_f;
  logic       fetch;
  logic       psh_done;
  logic       up_pc;
  logic       int_req;
  logic       push_all;
  logic [3:0] intvec;
  logic       set_i;
  logic       set_f;
  logic       nmi_armed;

  modport master (
    output cen, nmi_n, firq_n, irq_n, mask_i, mask_f, fetch, psh_done, up_pc,
    input  int_req, push_all, intvec, set_i, set_f, nmi_armed
  );

  modport slave (
    input  cen, nmi_n, firq_n, irq_n, mask_i, mask_f, fetch, psh_done, up_pc,
    output int_req, push_all, intvec, set_i, set_f, nmi_armed
  );

endinterface

// File: rtl/jtkcpu_intsync.sv
// jtkcpu_intsync
// Two-flop synchroniser for one asynchronous active-low interrupt line plus
// a falling-edge detector.
//   i_clk, i_rst_n : clock, async active-low reset (flops reset to 1)
//   i_cen          : CPU clock enable, paces the edge detector only
//   i_line_n       : raw asynchronous line
//   o_sync_n       : synchronised line level
//   o_fall         : synchronised 1->0 transition seen since the last cen
module jtkcpu_intsync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cen,
  input  logic i_line_n,
  output logic o_sync_n,
  output logic o_fall
);

  logic r_meta_n;
  logic r_sync_n;
  logic r_prev_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta_n <= 1'b1;
      r_sync_n <= 1'b1;
    end else begin
      r_meta_n <= i_line_n;
      r_sync_n <= r_meta_n;
    end
  end

  // The previous level is sampled on cen so an edge that lands between two
  // cen cycles is still seen at the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev_n <= 1'b1;
    else if (i_cen) r_prev_n <= r_sync_n;
  end

  assign o_sync_n = r_sync_n;
  assign o_fall   = r_prev_n & ~r_sync_n;

endmodule

// File: rtl/jtkcpu_intsched.sv
// jtkcpu_intsched
// Interrupt scheduler: arbitrates NMI > FIRQ > IRQ at instruction
// boundaries, asks the control unit to stack state and hands the vector code
// to the memory controller. Also issues the reset vector after reset.
//   clk, rst_n : CPU clock, async active-low reset
//   bus        : jtkcpu_intsched_if.slave (see interface for signal list)
//
// state | meaning
// RSTV  | reset vector on intvec, waiting for up_pc
// IDLE  | arbitrating at each fetch
// PUSH  | int_req high, control unit stacking registers
// VEC   | winner's vector on intvec, waiting for up_pc
module jtkcpu_intsched
  import jtkcpu_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  jtkcpu_intsched_if.slave bus
);

  int_state_t r_state, w_state_nx;
  logic [3:0] r_win, w_win_nx;
  logic [3:0] r_intvec, w_intvec_nx;
  logic       r_int_req, w_int_req_nx;
  logic       r_push_all, w_push_all_nx;
  logic       r_set_i, w_set_i_nx;
  logic       r_set_f, w_set_f_nx;
  logic       r_nmi_armed, w_nmi_armed_nx;
  logic       r_nmi_pend, w_nmi_pend_nx;
  logic       r_first;
  logic       w_nmi_clr;

  logic w_nmi_fall, w_unused_nmi_sync_n;
  logic w_firq_sync_n, w_unused_firq_fall;
  logic w_irq_sync_n, w_unused_irq_fall;
  logic w_nmi_req, w_firq_el, w_irq_el;

  jtkcpu_intsync u_sync_nmi (
    .i_clk(clk), .i_rst_n(rst_n), .i_cen(bus.cen), .i_line_n(bus.nmi_n),
    .o_sync_n(w_unused_nmi_sync_n), .o_fall(w_nmi_fall)
  );

  jtkcpu_intsync u_sync_firq (
    .i_clk(clk), .i_rst_n(rst_n), .i_cen(bus.cen), .i_line_n(bus.firq_n),
    .o_sync_n(w_firq_sync_n), .o_fall(w_unused_firq_fall)
  );

  jtkcpu_intsync u_sync_irq (
    .i_clk(clk), .i_rst_n(rst_n), .i_cen(bus.cen), .i_line_n(bus.irq_n),
    .o_sync_n(w_irq_sync_n), .o_fall(w_unused_irq_fall)
  );

  // A fresh edge counts on the same cen it is seen, so it can win
  // arbitration against level sources asserted at the same time.
  assign w_nmi_req = r_nmi_pend | (w_nmi_fall & r_nmi_armed);
  assign w_firq_el = ~w_firq_sync_n & ~bus.mask_f;
  assign w_irq_el  = ~w_irq_sync_n & ~bus.mask_i;

  // A new edge coinciding with the NMI vector issue stays pending.
  assign w_nmi_pend_nx = (r_nmi_pend & ~w_nmi_clr) | (w_nmi_fall & r_nmi_armed);

  always_comb begin
    w_state_nx     = r_state;
    w_win_nx       = r_win;
    w_intvec_nx    = r_intvec;
    w_int_req_nx   = r_int_req;
    w_push_all_nx  = r_push_all;
    w_set_i_nx     = r_first;
    w_set_f_nx     = r_first;
    w_nmi_armed_nx = r_nmi_armed;
    w_nmi_clr      = 1'b0;
    case (r_state)
      ST_RSTV: begin
        if (bus.up_pc) begin
          w_state_nx     = ST_IDLE;
          w_intvec_nx    = VEC_NONE;
          w_nmi_armed_nx = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.fetch && (w_nmi_req || w_firq_el || w_irq_el)) begin
          if (w_nmi_req)      w_win_nx = VEC_NMI;
          else if (w_firq_el) w_win_nx = VEC_FIRQ;
          else                w_win_nx = VEC_IRQ;
          w_push_all_nx = (w_win_nx != VEC_FIRQ);
          w_int_req_nx  = 1'b1;
          w_state_nx    = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (bus.psh_done) begin
          w_int_req_nx = 1'b0;
          w_intvec_nx  = r_win;
          w_set_i_nx   = 1'b1;
          w_set_f_nx   = sets_f(r_win);
          w_nmi_clr    = (r_win == VEC_NMI);
          w_state_nx   = ST_VEC;
        end
      end
      ST_VEC: begin
        if (bus.up_pc) begin
          w_intvec_nx   = VEC_NONE;
          w_push_all_nx = 1'b0;
          w_state_nx    = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RSTV;
      r_win       <= VEC_NONE;
      r_intvec    <= VEC_RST;
      r_int_req   <= 1'b0;
      r_push_all  <= 1'b0;
      r_set_i     <= 1'b0;
      r_set_f     <= 1'b0;
      r_nmi_armed <= 1'b0;
      r_nmi_pend  <= 1'b0;
      r_first     <= 1'b1;
    end else if (bus.cen) begin
      r_state     <= w_state_nx;
      r_win       <= w_win_nx;
      r_intvec    <= w_intvec_nx;
      r_int_req   <= w_int_req_nx;
      r_push_all  <= w_push_all_nx;
      r_set_i     <= w_set_i_nx;
      r_set_f     <= w_set_f_nx;
      r_nmi_armed <= w_nmi_armed_nx;
      r_nmi_pend  <= w_nmi_pend_nx;
      r_first     <= 1'b0;
    end
  end

  assign bus.int_req   = r_int_req;
  assign bus.push_all  = r_push_all;
  assign bus.intvec    = r_intvec;
  assign bus.set_i     = r_set_i;
  assign bus.set_f     = r_set_f;
  assign bus.nmi_armed = r_nmi_armed;

endmodule

// File: tb/tb_jtkcpu_intsched.sv
// tb_jtkcpu_intsched
// Directed table vectors, hand-written corner sequences and a randomized run
// against a behavioural model of the interrupt scheduler.
module tb_jtkcpu_intsched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b1;
  logic nmi_n = 1'b1, firq_n = 1'b1, irq_n = 1'b1;
  logic mask_i = 1'b0, mask_f = 1'b0;
  logic fetch = 1'b0, psh_done = 1'b0, up_pc = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  jtkcpu_intsched_if bus ();

  assign bus.cen      = cen;
  assign bus.nmi_n    = nmi_n;
  assign bus.firq_n   = firq_n;
  assign bus.irq_n    = irq_n;
  assign bus.mask_i   = mask_i;
  assign bus.mask_f   = mask_f;
  assign bus.fetch    = fetch;
  assign bus.psh_done = psh_done;
  assign bus.up_pc    = up_pc;

  jtkcpu_intsched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Synchronised line = raw line as it was two clk edges ago.
  bit   h_nmi[2], h_firq[2], h_irq[2];
  bit   m_prev, m_pend, m_armed, m_first;
  int   m_phase;  // 0 reset vector, 1 idle, 2 stacking, 3 vectoring
  logic [3:0] m_win;
  logic e_int_req, e_push_all, e_set_i, e_set_f;
  logic [3:0] e_intvec;

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      h_nmi[k] = 1'b1; h_firq[k] = 1'b1; h_irq[k] = 1'b1;
    end
    m_prev = 1'b1; m_pend = 1'b0; m_armed = 1'b0; m_first = 1'b1;
    m_phase = 0; m_win = 4'b0000;
    e_int_req = 1'b0; e_push_all = 1'b0; e_set_i = 1'b0; e_set_f = 1'b0;
    e_intvec = 4'b1000;
  endtask

  task automatic m_cen(input bit s_nmi, input bit s_firq, input bit s_irq);
    bit fall;
    logic [3:0] w;
    fall = m_prev && !s_nmi && m_armed;
    e_set_i = m_first;
    e_set_f = m_first;
    m_first = 1'b0;
    case (m_phase)
      0: if (up_pc) begin m_phase = 1; e_intvec = 4'b0000; m_armed = 1'b1; end
      1: if (fetch) begin
        w = 4'b0000;
        if (m_pend || fall)          w = 4'b0100;
        else if (!s_firq && !mask_f) w = 4'b0010;
        else if (!s_irq && !mask_i)  w = 4'b0001;
        if (w != 4'b0000) begin
          m_win = w; m_phase = 2; e_int_req = 1'b1;
          e_push_all = (w != 4'b0010);
        end
      end
      2: if (psh_done) begin
        e_int_req = 1'b0; e_intvec = m_win; e_set_i = 1'b1;
        e_set_f = (m_win != 4'b0001);
        if (m_win == 4'b0100) m_pend = 1'b0;
        m_phase = 3;
      end
      default: if (up_pc) begin e_intvec = 4'b0000; e_push_all = 1'b0; m_phase = 1; end
    endcase
    if (fall) m_pend = 1'b1;
    m_prev = s_nmi;
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else begin
      if (cen) m_cen(h_nmi[1], h_firq[1], h_irq[1]);
      h_nmi[1] = h_nmi[0];   h_nmi[0] = nmi_n;
      h_firq[1] = h_firq[0]; h_firq[0] = firq_n;
      h_irq[1] = h_irq[0];   h_irq[0] = irq_n;
    end
  end

  // ---------------- checking helpers ----------------
  function automatic logic [8:0] outs();
    return {bus.int_req, bus.push_all, bus.intvec, bus.set_i, bus.set_f, bus.nmi_armed};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got req/pa/vec/si/sf/arm=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    bit         rst, nmi, firq, irq, mi, mf, fe, pd, up;
    logic [8:0] exp;  // {int_req, push_all, intvec, set_i, set_f, nmi_armed}
  } vec_t;

  function automatic vec_t mk(input string name, input bit rst, input bit nmi, input bit firq,
                              input bit irq, input bit mi, input bit mf, input bit fe,
                              input bit pd, input bit up, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.nmi = nmi; v.firq = firq; v.irq = irq;
    v.mi = mi; v.mf = mf; v.fe = fe; v.pd = pd; v.up = up; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n = v.rst; nmi_n = v.nmi; firq_n = v.firq; irq_n = v.irq;
    mask_i = v.mi; mask_f = v.mf; fetch = v.fe; psh_done = v.pd; up_pc = v.up;
    cen = 1'b1;
    @(posedge clk); #1;
    chk(v.name, outs(), v.exp);
  endtask

  localparam logic [8:0] X_RST  = 9'b0_0_1000_0_0_0;
  localparam logic [8:0] X_IDLE = 9'b0_0_0000_0_0_1;

  vec_t tbl[$];

  initial begin
    //             name           rst nmi fq iq mi mf fe pd up  expected
    tbl.push_back(mk("reset",        0, 1, 1, 1, 0, 0, 0, 0, 0, X_RST));
    tbl.push_back(mk("first_cen",    1, 1, 1, 1, 0, 0, 0, 0, 0, 9'b0_0_1000_1_1_0));
    tbl.push_back(mk("rstv_hold",    1, 1, 1, 1, 0, 0, 1, 0, 0, 9'b0_0_1000_0_0_0));
    tbl.push_back(mk("rstv_exit",    1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    tbl.push_back(mk("up_pc_idle",   1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    tbl.push_back(mk("irq_sync1",    1, 1, 1, 0, 0, 0, 0, 0, 0, X_IDLE));
    tbl.push_back(mk("irq_latency",  1, 1, 1, 0, 0, 0, 1, 0, 0, X_IDLE));
    tbl.push_back(mk("irq_req",      1, 1, 1, 0, 0, 0, 1, 0, 0, 9'b1_1_0000_0_0_1));
    tbl.push_back(mk("push_hold",    1, 1, 1, 1, 0, 0, 1, 0, 1, 9'b1_1_0000_0_0_1));
    tbl.push_back(mk("irq_vec",      1, 1, 1, 1, 0, 0, 0, 1, 0, 9'b0_1_0001_1_0_1));
    tbl.push_back(mk("vec_hold",     1, 1, 1, 1, 0, 0, 1, 1, 0, 9'b0_1_0001_0_0_1));
    tbl.push_back(mk("irq_return",   1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    tbl.push_back(mk("irq_gone",     1, 1, 1, 1, 0, 0, 1, 1, 0, X_IDLE));
    tbl.push_back(mk("firq_sync1",   1, 1, 0, 1, 0, 1, 0, 0, 0, X_IDLE));
    tbl.push_back(mk("firq_sync2",   1, 1, 0, 1, 0, 1, 0, 0, 0, X_IDLE));
    tbl.push_back(mk("firq_masked",  1, 1, 0, 1, 0, 1, 1, 0, 0, X_IDLE));
    tbl.push_back(mk("firq_req",     1, 1, 0, 1, 0, 0, 1, 0, 0, 9'b1_0_0000_0_0_1));
    tbl.push_back(mk("firq_vec",     1, 1, 0, 1, 0, 0, 0, 1, 0, 9'b0_0_0010_1_1_1));
    tbl.push_back(mk("firq_return",  1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    tbl.push_back(mk("firq_settle",  1, 1, 1, 1, 0, 0, 0, 0, 0, X_IDLE));
    tbl.push_back(mk("firq_gone",    1, 1, 1, 1, 0, 0, 1, 0, 0, X_IDLE));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // NMI, FIRQ and IRQ together: NMI wins, FIRQ follows after return.
    apply(mk("all3_s1",        1, 0, 0, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("all3_s2",        1, 0, 0, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("nmi_wins_req",   1, 0, 0, 0, 0, 0, 1, 0, 0, 9'b1_1_0000_0_0_1));
    apply(mk("nmi_vec",        1, 1, 0, 1, 0, 0, 0, 1, 0, 9'b0_1_0100_1_1_1));
    apply(mk("no_rearb_vec",   1, 1, 0, 1, 0, 0, 1, 0, 0, 9'b0_1_0100_0_0_1));
    apply(mk("nmi_return",     1, 1, 0, 1, 0, 0, 0, 0, 1, X_IDLE));
    apply(mk("firq_after_nmi", 1, 1, 0, 1, 0, 0, 1, 0, 0, 9'b1_0_0000_0_0_1));
    apply(mk("firq2_vec",      1, 1, 1, 1, 0, 0, 0, 1, 0, 9'b0_0_0010_1_1_1));
    apply(mk("firq2_return",   1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    apply(mk("settle",         1, 1, 1, 1, 0, 0, 0, 0, 0, X_IDLE));

    // NMI edge during VEC of an IRQ is serviced right after return.
    apply(mk("irq2_s1",        1, 1, 1, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("irq2_s2",        1, 1, 1, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("irq2_req",       1, 1, 1, 0, 0, 0, 1, 0, 0, 9'b1_1_0000_0_0_1));
    apply(mk("irq2_vec",       1, 1, 1, 1, 0, 0, 0, 1, 0, 9'b0_1_0001_1_0_1));
    apply(mk("nmi_in_vec1",    1, 0, 1, 1, 0, 0, 0, 0, 0, 9'b0_1_0001_0_0_1));
    apply(mk("nmi_in_vec2",    1, 0, 1, 1, 0, 0, 0, 0, 0, 9'b0_1_0001_0_0_1));
    apply(mk("nmi_in_vec3",    1, 0, 1, 1, 0, 0, 1, 0, 0, 9'b0_1_0001_0_0_1));
    apply(mk("irq2_return",    1, 0, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    apply(mk("nmi_after_ret",  1, 0, 1, 1, 0, 0, 1, 0, 0, 9'b1_1_0000_0_0_1));
    apply(mk("nmi2_vec",       1, 1, 1, 1, 0, 0, 0, 1, 0, 9'b0_1_0100_1_1_1));
    apply(mk("nmi2_return",    1, 1, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    apply(mk("nmi_cleared",    1, 1, 1, 1, 0, 0, 1, 0, 0, X_IDLE));

    // NMI edge before arming is dropped.
    apply(mk("reset2",         0, 1, 1, 1, 0, 0, 0, 0, 0, X_RST));
    apply(mk("unarm_first",    1, 0, 1, 1, 0, 0, 0, 0, 0, 9'b0_0_1000_1_1_0));
    apply(mk("unarm_s2",       1, 0, 1, 1, 0, 0, 0, 0, 0, 9'b0_0_1000_0_0_0));
    apply(mk("unarm_edge",     1, 0, 1, 1, 0, 0, 1, 0, 0, 9'b0_0_1000_0_0_0));
    apply(mk("unarm_exit",     1, 0, 1, 1, 0, 0, 0, 0, 1, X_IDLE));
    apply(mk("nmi_unarmed",    1, 0, 1, 1, 0, 0, 1, 0, 0, X_IDLE));
    apply(mk("nmi_release",    1, 1, 1, 1, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("nmi_settle",     1, 1, 1, 1, 0, 0, 1, 0, 0, X_IDLE));

    // Reset asserted in the middle of PUSH acts without a clock edge.
    apply(mk("irq3_s1",        1, 1, 1, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("irq3_s2",        1, 1, 1, 0, 0, 0, 0, 0, 0, X_IDLE));
    apply(mk("irq3_req",       1, 1, 1, 0, 0, 0, 1, 0, 0, 9'b1_1_0000_0_0_1));
    #2 rst_n = 1'b0;
    #1 chk("rst_in_push", outs(), X_RST);

    // Randomized run against the model.
    irq_n = 1'b1; fetch = 1'b0; psh_done = 1'b0; up_pc = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(0, 9) == 0)  firq_n = ~firq_n;
      if ($urandom_range(0, 9) == 0)  irq_n = ~irq_n;
      if ($urandom_range(0, 19) == 0) mask_i = ~mask_i;
      if ($urandom_range(0, 19) == 0) mask_f = ~mask_f;
      fetch    = ($urandom_range(0, 2) == 0);
      psh_done = ($urandom_range(0, 3) == 0);
      up_pc    = ($urandom_range(0, 3) == 0);
      if (i == 3000) begin rst_n = 1'b0; m_reset(); end
      if (i == 3003) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rand", outs(), {e_int_req, e_push_all, e_intvec, e_set_i, e_set_f, m_armed});
      chk("onehot", {8'b0, $onehot0(bus.intvec)}, 9'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtkcpu_intsched.md
JTKCPU_INTSCHED -- requirements
Module: jtkcpu_intsched

Interface
REQ-001 SHALL: clk  in  1  CPU clock, rising edge. One clock only.
REQ-002 SHALL: rst_n  in  1  reset. Asynchronous assertion, active-low.
REQ-003 SHALL: cen  in  1  CPU clock enable. All state advances only on clk edges with cen=1, except the input synchronisers.
REQ-004 SHALL: nmi_n, firq_n, irq_n  in  1 each  external interrupt lines, active-low, asynchronous.
REQ-005 SHALL: mask_i, mask_f  in  1 each  CC I and F flags from the register file.
REQ-006 SHALL: fetch  in  1  instruction boundary (opcode fetch cycle).
REQ-007 SHALL: psh_done  in  1  control unit finished stacking registers.
REQ-008 SHALL: up_pc  in  1  memory controller loaded PC from the vector.
REQ-009 SHALL: int_req  out  1  request to the control unit to start interrupt stacking.
REQ-010 SHALL: push_all  out  1  1 = stack entire state (IRQ/NMI); 0 = PC+CC only (FIRQ).
REQ-011 SHALL: intvec  out  4  one-hot vector code to the memory controller: 0001 IRQ, 0010 FIRQ, 0100 NMI, 1000 RST, 0000 none.
REQ-012 SHALL: set_i, set_f  out  1 each  one-cen pulses that set CC I/F.
REQ-013 SHALL: nmi_armed  out  1  NMI acceptance enabled.

Function
REQ-014 SHALL: FSM states RSTV, IDLE, PUSH, VEC.
REQ-015 SHALL: RSTV drives intvec=1000 without stacking. On up_pc it moves to IDLE and sets nmi_armed=1.
REQ-016 SHALL: nmi_n, firq_n and irq_n pass through 2-flop synchronisers clocked every clk. Interrupt latency counts from synchronised values.
REQ-017 SHALL: NMI pending latches on a synchronised falling edge detected on a cen cycle while nmi_armed=1. It clears only when the NMI vector is issued.
REQ-018 SHALL: FIRQ and IRQ are level-sensitive. FIRQ is eligible when firq_n=0 and mask_f=0. IRQ is eligible when irq_n=0 and mask_i=0.
REQ-019 SHALL: in IDLE, fetch=1 with any eligible source: latch the winner (priority NMI > FIRQ > IRQ), assert int_req, drive push_all, and enter PUSH. All of this happens on that same cen edge.
REQ-020 SHALL: the winner stays locked through PUSH and VEC. Later changes to masks or line levels do not alter it.
REQ-021 SHALL: int_req stays high for the whole of PUSH.
REQ-022 SHALL: PUSH plus psh_done: drop int_req, drive intvec with the winner's code, and enter VEC.
REQ-023 SHALL: the set_i/set_f pulse fires on the PUSH->VEC transition. IRQ sets I. FIRQ sets I and F. NMI sets I and F.
REQ-024 SHALL: VEC holds intvec until up_pc. Then intvec=0000 and the FSM returns to IDLE.
REQ-025 SHALL: no new arbitration occurs before IDLE is re-entered. A request pending at that point is taken at the next fetch.
REQ-026 SHALL: an NMI edge arriving during PUSH or VEC stays pending and is serviced at the next boundary.
REQ-027 SHALL: up_pc is ignored in IDLE and PUSH. psh_done is ignored outside PUSH.
REQ-028 SHALL: intvec is zero-or-one-hot in every cycle.

Reset
REQ-029 SHALL: rst_n low forces state RSTV, intvec=1000, int_req=0, push_all=0, set_i=0, set_f=0, nmi_armed=0, NMI pending=0 and synchronisers=1. This applies in any state, mid-operation included.
REQ-030 SHALL: set_i and set_f are 1 at the first cen after reset release, masking IRQ/FIRQ until software clears them.

Structure
REQ-031 SHALL: jtkcpu_pkg holds the vector codes (VEC_IRQ/FIRQ/NMI/RST) and the FSM state encoding. jtkcpu_memctrl shares the vector codes.
REQ-032 SHALL: one sub-module, jtkcpu_intsync, contains the 2-flop synchroniser plus the falling-edge detector. It is instantiated three times; the edge output is used only for NMI.

Verification
REQ-033 SHALL: reset release, then up_pc at cen 3 -> intvec=1000 until up_pc, then 0000; nmi_armed=1; no int_req.
REQ-034 SHALL: irq_n=0, mask_i=0, fetch -> int_req, push_all=1; psh_done -> intvec=0001 and a set_i pulse; up_pc -> IDLE.
REQ-035 SHALL: irq_n, firq_n and nmi edge all in the same cycle -> NMI wins (intvec=0100, push_all=1). FIRQ follows at the next fetch after return if still asserted and mask_f=0.
REQ-036 SHALL: firq_n=0 with mask_f=1 at fetch -> no int_req. Clearing mask_f -> request at the next fetch, push_all=0, intvec=0010.
REQ-037 SHALL: an NMI edge before nmi_armed is ignored. An NMI edge during VEC of an IRQ -> serviced right after return.
REQ-038 SHALL: rst_n low during PUSH -> int_req=0 and intvec=1000 immediately.
